// File: rtl/keypad_access_controller.sv
// keypad_access_controller
// Keypad lock: buffers NUM_DIGITS digits, checks them on submit, holds the door
// unlocked for UNLOCK_CYCLES, and locks the keypad out for LOCKOUT_CYCLES after
// MAX_FAILS consecutive failures. Abandoned entries are dropped after ENTRY_TIMEOUT
// idle cycles. One down-counter serves the timeout, unlock and lockout phases.
module keypad_access_controller #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIGIT_W        = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] CODE = 16'h92C7,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned UNLOCK_CYCLES  = 500,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned ENTRY_TIMEOUT  = 200
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              digit_valid,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              submit,
    input  logic                              clear,
    output logic                              door_unlocked,
    output logic                              locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digits_entered,
    output logic                              good_pulse,
    output logic                              bad_pulse
);

    localparam int unsigned BUF_W  = NUM_DIGITS * DIGIT_W;
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int unsigned CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int unsigned MAX_UL = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned MAX_T  = (MAX_UL > ENTRY_TIMEOUT) ? MAX_UL : ENTRY_TIMEOUT;
    localparam int unsigned TMR_W  = $clog2(MAX_T) + 1;

    localparam logic [CNT_W-1:0]  DIGITS_FULL = CNT_W'(NUM_DIGITS);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT  = FAIL_W'(MAX_FAILS);
    // Counter loads are N-1 so the phase lasts exactly N cycles ending at zero.
    localparam logic [TMR_W-1:0]  T_UNLOCK    = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  T_LOCKOUT   = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  T_ENTRY     = TMR_W'(ENTRY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0]    dig_q, dig_d;
    logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                door_q, door_d;
    logic                lock_q, lock_d;
    logic                good_q, good_d;
    logic                bad_q, bad_d;

    // State and datapath registers; reset aborts any unlock or lockout at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            dig_q   <= '0;
            fail_q  <= '0;
            tmr_q   <= '0;
            door_q  <= 1'b0;
            lock_q  <= 1'b0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            dig_q   <= dig_d;
            fail_q  <= fail_d;
            tmr_q   <= tmr_d;
            door_q  <= door_d;
            lock_q  <= lock_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    // Next-state and registered-output logic; submit > clear > digit_valid in IDLE/ENTRY.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        dig_d    = dig_q;
        fail_d   = fail_q;
        tmr_d    = tmr_q;
        door_d   = door_q;
        lock_d   = lock_q;
        good_d   = 1'b0;
        bad_d    = 1'b0;
        fail_inc = fail_q + 1'b1;

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (submit) begin
                    if (dig_q != '0) begin
                        buf_d = '0;
                        dig_d = '0;
                        if (dig_q == DIGITS_FULL && buf_q == CODE) begin
                            good_d  = 1'b1;
                            fail_d  = '0;
                            door_d  = 1'b1;
                            tmr_d   = T_UNLOCK;
                            state_d = S_UNLOCKED;
                        end else begin
                            bad_d  = 1'b1;
                            fail_d = fail_inc;
                            if (fail_inc == FAIL_LIMIT) begin
                                lock_d  = 1'b1;
                                tmr_d   = T_LOCKOUT;
                                state_d = S_LOCKOUT;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end else if (clear) begin
                    buf_d   = '0;
                    dig_d   = '0;
                    state_d = S_IDLE;
                end else if (digit_valid) begin
                    if (dig_q != DIGITS_FULL) begin
                        buf_d = (buf_q << DIGIT_W) | BUF_W'(digit_in);
                        dig_d = dig_q + 1'b1;
                    end
                    tmr_d   = T_ENTRY;
                    state_d = S_ENTRY;
                end else if (state_q == S_ENTRY) begin
                    if (tmr_q == '0) begin
                        buf_d   = '0;
                        dig_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
            end
            S_UNLOCKED: begin
                if (clear || tmr_q == '0) begin
                    door_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == '0) begin
                    lock_d  = 1'b0;
                    fail_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign door_unlocked  = door_q;
    assign locked_out     = lock_q;
    assign fail_count     = fail_q;
    assign digits_entered = dig_q;
    assign good_pulse     = good_q;
    assign bad_pulse      = bad_q;

endmodule
